// File: rtl/count_splitter_128_1.sv
// count_splitter_128_1: spreads a binary count into ODIM rotated unary lanes
// through a two-stage elastic pipeline.
module count_splitter_128_1 #(
    parameter int ODIM   = 128,
    parameter int ODL2   = $clog2(ODIM),
    parameter int IWID   = ODL2 + 1,
    parameter int STRIDE = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            iValid,
    output logic            iReady,
    input  logic [IWID-1:0] iData,
    input  logic            iRotEn,
    output logic            oValid,
    input  logic            oReady,
    output logic            oData [ODIM-1:0],
    output logic            oSat
);
    logic            s1_v, s1_sat, s2_v, s2_sat, adv, xfer, sat;
    logic [IWID-1:0] s1_c, c;
    logic [ODL2-1:0] r, s1_r, r_nxt;
    logic [ODIM-1:0] lanes, s2_data;

    always_comb begin
        adv    = s1_v & (~s2_v | oReady);
        iReady = ~s1_v | adv;
        xfer   = iValid & iReady;
        sat    = iData > IWID'(ODIM);
        c      = sat ? IWID'(ODIM) : iData;
        r_nxt  = ODL2'((int'(r) + STRIDE) % ODIM);
        // lane k is set when its distance past the run start, wrapped, is below c
        for (int k = 0; k < ODIM; k++)
            lanes[k] = ((k >= int'(s1_r)) ? k - int'(s1_r) : k + ODIM - int'(s1_r)) < int'(s1_c);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v    <= 1'b0;
            s1_c    <= '0;
            s1_sat  <= 1'b0;
            s1_r    <= '0;
            s2_v    <= 1'b0;
            s2_sat  <= 1'b0;
            s2_data <= '0;
            r       <= '0;
        end else begin
            if (xfer) begin
                s1_v   <= 1'b1;
                s1_c   <= c;
                s1_sat <= sat;
                s1_r   <= r;
                if (iRotEn) r <= r_nxt;
            end else if (adv) begin
                s1_v <= 1'b0;
            end
            if (adv) begin
                s2_v    <= 1'b1;
                s2_data <= lanes;
                s2_sat  <= s1_sat;
            end else if (oReady) begin
                s2_v <= 1'b0;
            end
        end
    end

    always_comb for (int k = 0; k < ODIM; k++) oData[k] = s2_data[k];
    assign oValid = s2_v;
    assign oSat   = s2_sat;
endmodule

// File: tb/tb_count_splitter_128_1.sv
// tb_count_splitter_128_1: directed checks of count_splitter_128_1 with
// hand-computed lane patterns.
module tb_count_splitter_128_1;
    logic         clk = 1'b0, rst = 1'b1, i_valid = 1'b0, i_rot_en = 1'b0, o_ready = 1'b1;
    logic         i_ready, o_valid, o_sat;
    logic [7:0]   i_data = '0;
    logic         o_data [127:0];
    logic [127:0] od, held;
    int           errors = 0, checks = 0, accepted;

    count_splitter_128_1 dut (
        .clk(clk), .rst(rst), .iValid(i_valid), .iReady(i_ready), .iData(i_data),
        .iRotEn(i_rot_en), .oValid(o_valid), .oReady(o_ready), .oData(o_data), .oSat(o_sat)
    );

    always #5 clk = ~clk;
    always_comb for (int k = 0; k < 128; k++) od[k] = o_data[k];

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc();
        cyc();
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_ovalid: got %b want 0", o_valid); end
        checks++; if (od !== '0) begin errors++; $display("FAIL reset_odata: got %h want 0", od); end
        checks++; if (o_sat !== 1'b0) begin errors++; $display("FAIL reset_osat: got %b want 0", o_sat); end
        rst = 1'b0;
        cyc();
        checks++; if (i_ready !== 1'b1) begin errors++; $display("FAIL reset_iready: got %b want 1", i_ready); end
    endtask

    task automatic test_basic();
        i_valid = 1'b1; i_data = 8'd5; i_rot_en = 1'b0;
        cyc();
        i_valid = 1'b0;
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL basic_early: got %b want 0", o_valid); end
        cyc();
        checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL basic_ovalid: got %b want 1", o_valid); end
        checks++; if (od !== 128'h1F) begin errors++; $display("FAIL basic_odata: got %h want %h", od, 128'h1F); end
        checks++; if (o_sat !== 1'b0) begin errors++; $display("FAIL basic_osat: got %b want 0", o_sat); end
        cyc();
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL basic_drain: got %b want 0", o_valid); end
    endtask

    task automatic test_saturate();
        i_valid = 1'b1; i_data = 8'd200;
        cyc();
        i_data = 8'd128;
        cyc();
        checks++; if (od !== {128{1'b1}}) begin errors++; $display("FAIL sat200_odata: got %h want all ones", od); end
        checks++; if (o_sat !== 1'b1) begin errors++; $display("FAIL sat200_osat: got %b want 1", o_sat); end
        i_data = 8'd0;
        cyc();
        i_valid = 1'b0;
        checks++; if (od !== {128{1'b1}}) begin errors++; $display("FAIL sat128_odata: got %h want all ones", od); end
        checks++; if (o_sat !== 1'b0) begin errors++; $display("FAIL sat128_osat: got %b want 0", o_sat); end
        cyc();
        checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL zero_ovalid: got %b want 1", o_valid); end
        checks++; if (od !== '0) begin errors++; $display("FAIL zero_odata: got %h want 0", od); end
        cyc();
    endtask

    task automatic test_back_to_back();
        i_valid = 1'b1; i_data = 8'd3; i_rot_en = 1'b1;
        cyc();
        cyc();
        checks++; if (od !== 128'h7) begin errors++; $display("FAIL rot0_odata: got %h want %h", od, 128'h7); end
        cyc();
        i_valid = 1'b0;
        checks++; if (od !== 128'hE) begin errors++; $display("FAIL rot1_odata: got %h want %h", od, 128'hE); end
        cyc();
        checks++; if (od !== 128'h1C) begin errors++; $display("FAIL rot2_odata: got %h want %h", od, 128'h1C); end
        checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL rot2_ovalid: got %b want 1", o_valid); end
        cyc();
    endtask

    task automatic test_wrap();
        // r is 3 here; 123 more rotating transfers bring it to 126
        i_valid = 1'b1; i_data = 8'd0; i_rot_en = 1'b1;
        repeat (123) cyc();
        i_data = 8'd4;
        cyc();
        i_data = 8'd1; i_rot_en = 1'b0;
        cyc();
        i_valid = 1'b0;
        checks++; if (od !== 128'hC0000000_00000000_00000000_00000003) begin errors++; $display("FAIL wrap_odata: got %h want c0..03", od); end
        cyc();
        checks++; if (od !== 128'h80000000_00000000_00000000_00000000) begin errors++; $display("FAIL wrap_next_r: got %h want 80..00", od); end
        cyc();
        cyc();
    endtask

    task automatic test_backpressure();
        o_ready = 1'b0; i_valid = 1'b1; i_rot_en = 1'b0; accepted = 0;
        for (int i = 0; i < 4; i++) begin
            i_data = 8'(10 * (i + 1));
            if (i_ready) accepted++;
            cyc();
            if (i == 1) held = od;
        end
        checks++; if (accepted != 2) begin errors++; $display("FAIL bp_accepted: got %0d want 2", accepted); end
        checks++; if (i_ready !== 1'b0) begin errors++; $display("FAIL bp_iready: got %b want 0", i_ready); end
        checks++; if (od !== held) begin errors++; $display("FAIL bp_stable: got %h want %h", od, held); end
        checks++; if (od !== 128'h80000000_00000000_00000000_000001FF) begin errors++; $display("FAIL bp_first: got %h want 80..1ff", od); end
        i_valid = 1'b0; o_ready = 1'b1;
        cyc();
        checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL bp_second_valid: got %b want 1", o_valid); end
        checks++; if ($countones(od) != 20) begin errors++; $display("FAIL bp_second_pop: got %0d want 20", $countones(od)); end
        cyc();
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL bp_empty: got %b want 0", o_valid); end
    endtask

    task automatic test_mid_reset();
        o_ready = 1'b0; i_valid = 1'b1; i_data = 8'd9; i_rot_en = 1'b1;
        cyc();
        cyc();
        checks++; if (i_ready !== 1'b0) begin errors++; $display("FAIL mr_full: got %b want 0", i_ready); end
        rst = 1'b1; i_data = 8'd7;
        cyc();
        rst = 1'b0; i_valid = 1'b0;
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL mr_ovalid: got %b want 0", o_valid); end
        checks++; if (od !== '0) begin errors++; $display("FAIL mr_odata: got %h want 0", od); end
        checks++; if (i_ready !== 1'b1) begin errors++; $display("FAIL mr_iready: got %b want 1", i_ready); end
        o_ready = 1'b1;
        cyc();
        cyc();
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL mr_phantom: got %b want 0", o_valid); end
        i_valid = 1'b1; i_data = 8'd2; i_rot_en = 1'b0;
        cyc();
        i_valid = 1'b0;
        cyc();
        checks++; if (od !== 128'h3) begin errors++; $display("FAIL mr_r0: got %h want %h", od, 128'h3); end
        checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL mr_after_valid: got %b want 1", o_valid); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturate();
        test_back_to_back();
        test_wrap();
        test_backpressure();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
